// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster constants and count type
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC;
    localparam int DEF_VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC;

    localparam int COUNT_W = 10;
    typedef logic [COUNT_W-1:0] count_t;

    function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-depth shift register with asynchronous reset value
module sync_delay_line #(
    parameter int                DEPTH     = 2,
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= RESET_VAL;
                    end
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, delayed syncs, line/frame strobes and frame timer
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int CLK_DIV    = 1,
    parameter int SYNC_DELAY = 2,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               timer_hold,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic [15:0]        timer,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam count_t H_LAST = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST = count_t'(V_TOTAL - 1);
    localparam count_t H_ACT  = count_t'(H_ACTIVE);
    localparam count_t V_ACT  = count_t'(V_ACTIVE);
    localparam count_t HS_LO  = count_t'(H_ACTIVE + H_FP);
    localparam count_t HS_HI  = count_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam count_t VS_LO  = count_t'(V_ACTIVE + V_FP);
    localparam count_t VS_HI  = count_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be in 1..16");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be in 0..7");
        end
    endgenerate

    logic [3:0] div_cnt;
    logic       tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    count_t h_nxt;
    count_t v_nxt;
    logic   h_wrap;

    always_comb begin
        h_nxt  = hcount;
        v_nxt  = vcount;
        h_wrap = 1'b0;
        if (tick) begin
            if (hcount == H_LAST) begin
                h_nxt  = '0;
                h_wrap = 1'b1;
                v_nxt  = (vcount == V_LAST) ? '0 : vcount + 10'd1;
            end else begin
                h_nxt = hcount + 10'd1;
            end
        end
    end

    // Everything below is registered from the next-state counts so it lines up with hcount/vcount.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            enable      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            line_start  <= h_wrap;
            frame_start <= h_wrap && (v_nxt == '0);
            if (tick) begin
                enable <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= 16'd0;
        end else if (h_wrap && (v_nxt == '0) && !timer_hold) begin
            timer <= timer + 16'd1;
        end
    end

    logic [1:0] sync_raw;
    logic [1:0] sync_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_raw <= {2{~SYNC_POL}};
        end else begin
            sync_raw[1] <= in_window(h_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
            sync_raw[0] <= in_window(v_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
        end
    end

    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .WIDTH     (2),
        .RESET_VAL ({2{~SYNC_POL}})
    ) u_sync_delay (
        .clock (clock),
        .reset (reset),
        .din   (sync_raw),
        .dout  (sync_out)
    );

    assign hsync = sync_out[1];
    assign vsync = sync_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int HSS = HA + HF;
    localparam int VSS = VA + VF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic timer_hold = 1'b0;

    logic [9:0]  ha, va, hb, vb;
    logic        ena, hsa, vsa, lsa, fsa;
    logic        enb, hsb, vsb, lsb, fsb;
    logic [15:0] tma, tmb;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(1), .SYNC_DELAY(2), .SYNC_POL(1'b0)
    ) dut_a (
        .clock(clock), .reset(reset), .timer_hold(timer_hold),
        .hcount(ha), .vcount(va), .enable(ena), .hsync(hsa), .vsync(vsa),
        .timer(tma), .line_start(lsa), .frame_start(fsa)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(2), .SYNC_DELAY(0), .SYNC_POL(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .timer_hold(timer_hold),
        .hcount(hb), .vcount(vb), .enable(enb), .hsync(hsb), .vsync(vsb),
        .timer(tmb), .line_start(lsb), .frame_start(fsb)
    );

    always #5 clock = ~clock;

    logic [40:0] obs_a, obs_b;
    assign obs_a = {ha, va, ena, hsa, vsa, lsa, fsa, tma};
    assign obs_b = {hb, vb, enb, hsb, vsb, lsb, fsb, tmb};

    int total = 0;
    int bad = 0;

    logic [40:0] qa[$];
    logic [40:0] qb[$];
    logic [40:0] ea, eb;

    int          k_m [2];
    logic [15:0] tm_m [2];
    logic [1:0]  raw_m [2][8];

    // Reference: position is derived from edges since release, not from a running counter.
    task automatic model_cycle(input int i, output logic [40:0] e);
        int div, sd, n, h, v;
        logic pol, tick, en, ls, fs, hr, vr;
        logic [1:0] so;
        div = (i == 0) ? 1 : 2;
        sd  = (i == 0) ? 2 : 0;
        pol = (i == 0) ? 1'b0 : 1'b1;
        if (reset) begin
            k_m[i]  = 0;
            tm_m[i] = 16'd0;
            e = {10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, 16'd0};
        end else begin
            k_m[i] = k_m[i] + 1;
            n = k_m[i] / div;
            h = n % HT;
            v = (n / HT) % VT;
            tick = (k_m[i] % div) == 0;
            en = (n > 0) && (h < HA) && (v < VA);
            ls = tick && (n > 0) && (h == 0);
            fs = ls && (v == 0);
            if (fs && !timer_hold) tm_m[i] = tm_m[i] + 16'd1;
            hr = (h >= HSS && h < HSS + HS) ? pol : ~pol;
            vr = (v >= VSS && v < VSS + VS) ? pol : ~pol;
            raw_m[i][k_m[i] % 8] = {hr, vr};
            so = (k_m[i] - sd >= 1) ? raw_m[i][(k_m[i] - sd) % 8] : {~pol, ~pol};
            e = {10'(h), 10'(v), en, so, ls, fs, tm_m[i]};
        end
    endtask

    always @(posedge clock) begin
        logic [40:0] e0, e1;
        model_cycle(0, e0);
        qa.push_back(e0);
        model_cycle(1, e1);
        qb.push_back(e1);
    end

    task automatic step();
        @(negedge clock);
        total++;
        if (qa.size() == 0 || qb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got qa=%0d qb=%0d want both >0", qa.size(), qb.size());
            ea = 'x;
            eb = 'x;
        end else begin
            ea = qa.pop_front();
            eb = qb.pop_front();
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (obs_a !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
                bad++; $display("FAIL reset_a_values got=%h want=%h", obs_a, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0});
            end
            total++;
            if (obs_b !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
                bad++; $display("FAIL reset_b_values got=%h want=%h", obs_b, {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
            end
        end
        reset = 1'b0;
        step();
        total++;
        if ({ha, va, ena} !== {10'd1, 10'd0, 1'b1}) begin
            bad++; $display("FAIL first_tick_a got h=%0d v=%0d en=%b want h=1 v=0 en=1", ha, va, ena);
        end
        total++;
        if (obs_a !== ea) begin bad++; $display("FAIL first_tick_a_model got=%h want=%h", obs_a, ea); end
        total++;
        if ({hb, enb} !== {10'd0, 1'b0}) begin
            bad++; $display("FAIL first_cycle_b got h=%0d en=%b want h=0 en=0", hb, enb);
        end
        step();
        total++;
        if ({hb, vb, enb} !== {10'd1, 10'd0, 1'b1}) begin
            bad++; $display("FAIL first_tick_b got h=%0d v=%0d en=%b want h=1 v=0 en=1", hb, vb, enb);
        end
        total++;
        if (obs_b !== eb) begin bad++; $display("FAIL first_tick_b_model got=%h want=%h", obs_b, eb); end
    endtask

    task automatic test_line();
        int c = 0, c_hs = -1, fall = -1, run = 0, en_low = 0;
        bit run_done = 0;
        logic prev_hs = hsa;
        logic [9:0] prev_v = va;
        while (va != 10'd2 && c < 4 * HT) begin
            step();
            c++;
            total++;
            if (obs_a !== ea) begin bad++; $display("FAIL line_model got=%h want=%h", obs_a, ea); end
            if (ha == 10'(HSS) && c_hs < 0) c_hs = c;
            if (prev_hs && !hsa && fall < 0) fall = c;
            if (fall >= 0 && !run_done) begin
                if (!hsa) run++;
                else run_done = 1;
            end
            if (va == 10'd1) en_low += (ena ? 0 : 1);
            if (va == 10'd1 && prev_v == 10'd0) begin
                total++;
                if ({ha, lsa} !== {10'd0, 1'b1}) begin
                    bad++; $display("FAIL line_wrap got h=%0d ls=%b want h=0 ls=1", ha, lsa);
                end
            end
            prev_hs = hsa;
            prev_v = va;
        end
        total++;
        if (va !== 10'd2) begin bad++; $display("FAIL line_timeout got v=%0d want 2", va); end
        total++;
        if (fall !== c_hs + 2) begin bad++; $display("FAIL hsync_start got cycle=%0d want %0d", fall, c_hs + 2); end
        total++;
        if (run !== HS) begin bad++; $display("FAIL hsync_width got=%0d want=%0d", run, HS); end
        total++;
        if (en_low !== HT - HA) begin bad++; $display("FAIL enable_blank got=%0d want=%0d", en_low, HT - HA); end
    endtask

    task automatic test_frame();
        int c = 0, c_vs = -1, fall = -1, run = 0;
        bit run_done = 0, found = 0;
        logic prev_vs = vsa;
        while (!found && c < 2 * FRAME) begin
            step();
            c++;
            total++;
            if (obs_a !== ea) begin bad++; $display("FAIL frame_model got=%h want=%h", obs_a, ea); end
            if (va == 10'(VSS) && ha == 10'd0 && c_vs < 0) c_vs = c;
            if (prev_vs && !vsa && fall < 0) fall = c;
            if (fall >= 0 && !run_done) begin
                if (!vsa) run++;
                else run_done = 1;
            end
            prev_vs = vsa;
            found = fsa;
        end
        total++;
        if (!found) begin bad++; $display("FAIL frame_timeout got fs=0 want fs=1"); end
        total++;
        if ({ha, va, tma} !== {10'd0, 10'd0, 16'd1}) begin
            bad++; $display("FAIL frame_wrap got h=%0d v=%0d timer=%0d want 0 0 1", ha, va, tma);
        end
        total++;
        if (fall !== c_vs + 2) begin bad++; $display("FAIL vsync_start got cycle=%0d want %0d", fall, c_vs + 2); end
        total++;
        if (run !== VS * HT) begin bad++; $display("FAIL vsync_width got=%0d want=%0d", run, VS * HT); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (fsa !== 1'b0) begin bad++; $display("FAIL frame_start_width got=%b want=0", fsa); end
        end
    endtask

    task automatic test_timer_wrap();
        int c = 0;
        bit found = 0;
        force dut_a.timer = 16'hFFFF;
        #1;
        release dut_a.timer;
        tm_m[0] = 16'hFFFF;
        total++;
        if (tma !== 16'hFFFF) begin bad++; $display("FAIL timer_preload got=%h want=ffff", tma); end
        while (!found && c < 2 * FRAME) begin
            step();
            c++;
            total++;
            if (obs_a !== ea) begin bad++; $display("FAIL wrap_model got=%h want=%h", obs_a, ea); end
            found = fsa;
        end
        total++;
        if (!found || tma !== 16'h0000) begin
            bad++; $display("FAIL timer_wrap got found=%b timer=%h want found=1 timer=0000", found, tma);
        end
        timer_hold = 1'b1;
        step();
        c = 0;
        found = 0;
        while (!found && c < 2 * FRAME) begin
            step();
            c++;
            total++;
            if (obs_a !== ea) begin bad++; $display("FAIL hold_model got=%h want=%h", obs_a, ea); end
            found = fsa;
        end
        total++;
        if (!found || tma !== 16'h0000) begin
            bad++; $display("FAIL timer_hold got found=%b timer=%h want found=1 timer=0000", found, tma);
        end
        timer_hold = 1'b0;
    endtask

    task automatic test_clkdiv();
        int since = 0, last_ls = -1;
        bit seen_change = 0;
        logic prev_ls = lsb;
        logic [9:0] prev_h = hb;
        for (int c = 0; c < 8 * HT; c++) begin
            step();
            since++;
            total++;
            if (obs_b !== eb) begin bad++; $display("FAIL clkdiv_model got=%h want=%h", obs_b, eb); end
            if (hb !== prev_h) begin
                if (seen_change) begin
                    total++;
                    if (since !== 2) begin bad++; $display("FAIL clkdiv_step got=%0d want=2", since); end
                end
                since = 0;
                seen_change = 1;
            end
            if (lsb) begin
                total++;
                if (prev_ls) begin bad++; $display("FAIL clkdiv_ls_width got=2+ want=1"); end
                if (last_ls >= 0) begin
                    total++;
                    if (c - last_ls !== 2 * HT) begin
                        bad++; $display("FAIL clkdiv_line_len got=%0d want=%0d", c - last_ls, 2 * HT);
                    end
                end
                last_ls = c;
            end
            prev_ls = lsb;
            prev_h = hb;
        end
        total++;
        if (last_ls < 0) begin bad++; $display("FAIL clkdiv_no_line got=none want=line_start"); end
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (ha == 10'd10 && va == 10'd5) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL mid_reset_timeout got=none want h=10 v=5"); end
        reset = 1'b1;
        #1;
        total++;
        if (obs_a !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            bad++; $display("FAIL mid_reset_a got=%h want=%h", obs_a, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0});
        end
        total++;
        if (obs_b !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            bad++; $display("FAIL mid_reset_b got=%h want=%h", obs_b, {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        end
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (obs_a !== ea || obs_b !== eb) begin
                bad++; $display("FAIL mid_reset_hold got=%h/%h want=%h/%h", obs_a, obs_b, ea, eb);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 3 * HT; c++) begin
            step();
            total++;
            if (obs_a !== ea) begin bad++; $display("FAIL resume_a got=%h want=%h", obs_a, ea); end
            total++;
            if (obs_b !== eb) begin bad++; $display("FAIL resume_b got=%h want=%h", obs_b, eb); end
            if (c == 0) begin
                total++;
                if (ha !== 10'd1) begin bad++; $display("FAIL resume_first got h=%0d want 1", ha); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_timer_wrap();
        test_clkdiv();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
